// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with a small register window per channel.
// Each channel runs its own IDLE/LOAD/CNT/EXPIRE sequencer; IRQ is the OR of unmasked pendings.

package multi_timer_pkg;
  typedef struct packed {
    logic        ctrl_we;
    logic        preset_we;
    logic        stat_w1c;
    logic [31:0] wdata;
  } ch_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        irq;
  } ch_rsp_t;
endpackage

module multi_timer_ch
  import multi_timer_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic       clk,
  input  logic       clr_n,
  input  ch_req_t    req,
  input  logic [1:0] rsel,
  output ch_rsp_t    rsp
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_EXPIRE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ctrl_q;
  logic [CW-1:0] preset_q;
  logic [CW-1:0] count_q, count_d;
  logic          pending_q;
  logic          pend_set;
  logic          en_clr;
  logic          auto_reload;
  logic          unused_wdata;

  assign auto_reload  = (ctrl_q[2:1] == 2'b01);
  assign unused_wdata = ^req.wdata;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_set = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        // Floors at zero, so PRESET=0 behaves exactly like PRESET=1
        if (count_q <= CW'(1)) begin
          count_d = '0;
          state_d = S_EXPIRE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      S_EXPIRE: begin
        pend_set = 1'b1;
        if (auto_reload) begin
          state_d = S_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A CTRL write restarts or stops the channel from any state
    if (req.ctrl_we) state_d = req.wdata[0] ? S_LOAD : S_IDLE;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (req.ctrl_we)    ctrl_q    <= req.wdata[3:0];
      else if (en_clr)    ctrl_q[0] <= 1'b0;
      if (req.preset_we)  preset_q  <= req.wdata[CW-1:0];
      if (pend_set)       pending_q <= 1'b1;
      else if (req.stat_w1c && req.wdata[0]) pending_q <= 1'b0;
    end
  end

  always_comb begin
    rsp = '0;
    case (rsel)
      2'd0:    rsp.rdata = {28'd0, ctrl_q};
      2'd1:    rsp.rdata = 32'(preset_q);
      2'd2:    rsp.rdata = 32'(count_q);
      default: rsp.rdata = {31'd0, pending_q};
    endcase
    rsp.irq = pending_q & ctrl_q[3];
  end

endmodule

module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CH = 2,
  parameter int CW = 32
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        WE_I,
  input  logic [5:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        IRQ
);

  logic [CH-1:0][31:0] rdata;
  logic [CH-1:0]       irq_vec;

  // Channel selects that decode beyond CH simply match nothing
  for (genvar g = 0; g < CH; g++) begin : g_ch
    ch_req_t req;
    ch_rsp_t rsp;
    logic    hit;

    assign hit           = (ADD_I[5:4] == 2'(g));
    assign req.ctrl_we   = WE_I & hit & (ADD_I[3:2] == 2'd0);
    assign req.preset_we = WE_I & hit & (ADD_I[3:2] == 2'd1);
    assign req.stat_w1c  = WE_I & hit & (ADD_I[3:2] == 2'd3);
    assign req.wdata     = DAT_I;

    multi_timer_ch #(.CW(CW)) u_ch (
      .clk  (clk),
      .clr_n(clr_n),
      .req  (req),
      .rsel (ADD_I[3:2]),
      .rsp  (rsp)
    );

    assign rdata[g]   = hit ? rsp.rdata : 32'd0;
    assign irq_vec[g] = rsp.irq;
  end

  always_comb begin
    DAT_O = '0;
    for (int i = 0; i < CH; i++) DAT_O = DAT_O | rdata[i];
  end

  assign IRQ = |irq_vec;

endmodule
